reg_disp: RTL and testbench

Board-level register viewer that sits directly downstream of the single-cycle CPU's debug register port. Drives `reg_sel` into the CPU, latches the returned `reg_data` once per display frame, and shows it in hex on an 8-digit multiplexed seven-segment display. Two debounced push-buttons step the selected register up or down, wrapping over 0..31.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 64 ++++++
 rtl/reg_disp.sv | 119 +++++++++++
 tb/tb_reg_disp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and helpers for the register viewer.
//   NUM_DIGITS : number of multiplexed seven-segment digits.
//   SEG_BLANK  : active-low pattern with every segment (and dp) off.
//   HEX_SEG    : nibble -> active-low segment table, dp bit (bit 7) set/off.
//   hex2seg    : table lookup with the dp bit driven from the freeze flag.
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;

    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Decimal point lights (active-low) while the display is frozen.
    function automatic logic [7:0] hex2seg(input logic [3:0] nib, input logic frozen);
        logic [7:0] s;
        s    = HEX_SEG[nib];
        s[7] = ~frozen;
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stable-level debounce counter and
// rising-edge press detect for one raw push-button.
//   clk, rst   : system clock, synchronous active-high reset
//   btn_raw    : asynchronous raw button input
//   btn_level  : debounced level
//   btn_press  : one-cycle pulse on a debounced 0->1 transition
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // The counter runs only while the synchronised input disagrees with the
    // accepted level; any agreement restarts it. On the DEB_CYCLES-th
    // disagreeing cycle the level flips and a rising flip emits the press.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: rtl/reg_disp.sv
// reg_disp: debug register viewer. Selects a CPU register with two
// debounced buttons and shows its value in hex on an 8-digit multiplexed
// seven-segment display, latching the value once per display frame.
//   clk, rst  : system clock, synchronous active-high reset
//   btn_next  : raw button, increments reg_sel (wraps 31 -> 0)
//   btn_prev  : raw button, decrements reg_sel (wraps 0 -> 31)
//   hold      : freeze displayed value; dp lit on every digit while set
//   reg_data  : register value returned by the CPU for reg_sel
//   reg_sel   : registered register index
//   an        : active-low digit enables, an[0] rightmost
//   seg       : active-low segments a..g on [6:0], dp on [7]
// Build option: define REG_DISP_LZB_EN for leading-zero blanking.
module reg_disp
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        hold,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_sel,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pcnt_q,     pcnt_d;
    logic [2:0]    dig_q,      dig_d;
    logic [31:0]   disp_val_q, disp_val_d;
    logic [4:0]    reg_sel_q,  reg_sel_d;
    logic [7:0]    an_q,       an_d;
    logic [7:0]    seg_q,      seg_d;

    logic       tick;
    logic [2:0] dig_nxt;
    logic [3:0] nibble;
    logic       next_press;
    logic       prev_press;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_next),
        .btn_level (),
        .btn_press (next_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_prev),
        .btn_level (),
        .btn_press (prev_press)
    );

    always_comb begin
        tick    = (pcnt_q == PCNT_MAX);
        dig_nxt = dig_q + 3'd1;

        pcnt_d     = tick ? '0 : pcnt_q + 1'b1;
        dig_d      = tick ? dig_nxt : dig_q;
        disp_val_d = disp_val_q;
        an_d       = an_q;
        seg_d      = seg_q;

        if (tick && (dig_q == 3'd7) && !hold) begin
            disp_val_d = reg_data;
        end

        // Decode from the value being latched so digit 0 of a new frame
        // already shows the new word and the whole frame stays coherent.
        nibble = disp_val_d[{dig_nxt, 2'b00} +: 4];

        if (tick) begin
            an_d  = ~(8'd1 << dig_nxt);
            seg_d = hex2seg(nibble, hold);
`ifdef REG_DISP_LZB_EN
            if ((dig_nxt != 3'd0) && ((disp_val_d >> {dig_nxt, 2'b00}) == 32'd0)) begin
                seg_d = {~hold, SEG_BLANK[6:0]};
            end
`endif
        end

        unique case ({next_press, prev_press})
            2'b10:   reg_sel_d = reg_sel_q + 5'd1;
            2'b01:   reg_sel_d = reg_sel_q - 5'd1;
            default: reg_sel_d = reg_sel_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q     <= '0;
            dig_q      <= '0;
            disp_val_q <= '0;
            reg_sel_q  <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
        end else begin
            pcnt_q     <= pcnt_d;
            dig_q      <= dig_d;
            disp_val_q <= disp_val_d;
            reg_sel_q  <= reg_sel_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign reg_sel = reg_sel_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule

// File: tb/tb_reg_disp.sv
// tb_reg_disp: self-checking bench for reg_disp with SCAN_DIV=4, DEB_CYCLES=8.
// A frame-level reference model (edges since reset, tick number, frame
// capture) checks an/seg every cycle; table vectors and hand sequences
// check display frames, hold, reset and button stepping.
module tb_reg_disp;

    localparam int SD = 4;
    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] reg_data = '0;
    logic [4:0]  reg_sel;
    logic [7:0]  an;
    logic [7:0]  seg;

    int cmp  = 0;
    int mism = 0;
    int model_sel = 0;

    logic [7:0] segtbl [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    reg_disp #(.SCAN_DIV(SD), .DEB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .hold     (hold),
        .reg_data (reg_data),
        .reg_sel  (reg_sel),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: display derived from edge count since reset.
    int unsigned e = 0;
    logic [31:0] frame = '0;
    logic [7:0]  exp_an = 8'hFF;
    logic [7:0]  exp_seg = 8'hFF;

    always @(posedge clk) begin
        int unsigned k, d, nib;
        if (rst) begin
            e = 0;
            frame = '0;
            exp_an = 8'hFF;
            exp_seg = 8'hFF;
        end else begin
            e++;
            if (e % SD == 0) begin
                k = e / SD;
                d = k % 8;
                if (d == 0 && !hold) frame = reg_data;
                exp_an = ~(8'd1 << d);
                nib = (frame >> (4 * d)) & 32'hF;
                exp_seg = {~hold, segtbl[nib][6:0]};
`ifdef REG_DISP_LZB_EN
                if (d != 0 && (frame >> (4 * d)) == 0) exp_seg = {~hold, 7'h7F};
`endif
            end
        end
        #1;
        chk("cont_an", {24'h0, an}, {24'h0, exp_an});
        chk("cont_seg", {24'h0, seg}, {24'h0, exp_seg});
    end

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        chk("rst_an", {24'h0, an}, 32'hFF);
        chk("rst_seg", {24'h0, seg}, 32'hFF);
        chk("rst_sel", {27'h0, reg_sel}, 32'h0);
        model_sel = 0;
        rst = 1'b0;
    endtask

    // Raise the selected raw buttons together for nl / pl cycles.
    task automatic press_test(input int nl, input int pl, input string nm);
        int delta, exp_sel;
        delta = ((nl >= DB) ? 1 : 0) - ((pl >= DB) ? 1 : 0);
        exp_sel = (model_sel + delta + 32) % 32;
        btn_next = (nl > 0);
        btn_prev = (pl > 0);
        for (int c = 1; c <= 40; c++) begin
            step(1);
            if (c == nl) btn_next = 1'b0;
            if (c == pl) btn_prev = 1'b0;
            if (c == DB + 2) chk({nm, "_before"}, {27'h0, reg_sel}, model_sel);
            if (c == DB + 3) chk({nm, "_after"}, {27'h0, reg_sel}, exp_sel);
        end
        chk({nm, "_settled"}, {27'h0, reg_sel}, exp_sel);
        model_sel = exp_sel;
    endtask

    typedef struct {
        logic [31:0] data;
        logic        hold;
        int          dig;
        logic [7:0]  seg;
    } dvec_t;

    typedef struct {
        int nl;
        int pl;
    } bvec_t;

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        mism++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $fatal(1, "timeout");
    end

    initial begin
        dvec_t dv[$];
        bvec_t bv[$];
        logic [7:0] lz2, lz7, hz5;

`ifdef REG_DISP_LZB_EN
        lz2 = 8'hFF; lz7 = 8'hFF; hz5 = 8'h7F;
`else
        lz2 = 8'hC0; lz7 = 8'hC0; hz5 = 8'h40;
`endif
        dv.push_back('{32'h1234ABCD, 1'b0, 0, 8'hA1});
        dv.push_back('{32'h1234ABCD, 1'b0, 1, 8'hC6});
        dv.push_back('{32'h1234ABCD, 1'b0, 2, 8'h83});
        dv.push_back('{32'h1234ABCD, 1'b0, 3, 8'h88});
        dv.push_back('{32'h1234ABCD, 1'b0, 4, 8'h99});
        dv.push_back('{32'h1234ABCD, 1'b0, 5, 8'hB0});
        dv.push_back('{32'h1234ABCD, 1'b0, 6, 8'hA4});
        dv.push_back('{32'h1234ABCD, 1'b0, 7, 8'hF9});
        dv.push_back('{32'h000000A0, 1'b0, 0, 8'hC0});
        dv.push_back('{32'h000000A0, 1'b0, 1, 8'h88});
        dv.push_back('{32'h000000A0, 1'b0, 2, lz2});
        dv.push_back('{32'h000000A0, 1'b0, 7, lz7});
        dv.push_back('{32'hFFFFFFFF, 1'b0, 3, 8'h8E});
        dv.push_back('{32'h00000005, 1'b1, 0, 8'h40});
        dv.push_back('{32'h00000005, 1'b1, 5, hz5});

        // Reset state and first lit digit.
        do_reset();
        step(SD - 1);
        chk("first_tick_pre_an", {24'h0, an}, 32'hFF);
        step(1);
        chk("first_tick_an", {24'h0, an}, 32'hFD);

        // Display table.
        foreach (dv[i]) begin
            reg_data = dv[i].data;
            hold = dv[i].hold;
            do_reset();
            step(SD * 8 + SD * dv[i].dig);
            chk($sformatf("disp%0d_an", i), {24'h0, an}, {24'h0, ~(8'd1 << dv[i].dig)});
            chk($sformatf("disp%0d_seg", i), {24'h0, seg}, {24'h0, dv[i].seg});
        end
        hold = 1'b0;

        // Hold freezes the frame; release takes effect at the next frame.
        reg_data = 32'h5;
        do_reset();
        step(SD * 8);
        chk("hold_pre_seg", {24'h0, seg}, 32'h92);
        hold = 1'b1;
        reg_data = 32'h9;
        step(SD * 8);
        chk("hold_on_an", {24'h0, an}, 32'hFE);
        chk("hold_on_seg", {24'h0, seg}, 32'h12);
        hold = 1'b0;
        step(SD * 8);
        chk("hold_off_seg", {24'h0, seg}, 32'h90);

        // Button table: wrap down, wrap up, glitches, simultaneous presses.
        bv.push_back('{0, 20});
        bv.push_back('{20, 0});
        bv.push_back('{20, 0});
        bv.push_back('{5, 0});
        bv.push_back('{0, 7});
        bv.push_back('{8, 0});
        bv.push_back('{0, 8});
        bv.push_back('{20, 20});
        bv.push_back('{DB - 1, DB});
        foreach (bv[i]) press_test(bv[i].nl, bv[i].pl, $sformatf("btn%0d", i));

        // Reset mid-frame and mid-debounce.
        press_test(20, 0, "pre_rst");
        step(6);
        btn_next = 1'b1;
        step(6);
        rst = 1'b1;
        btn_next = 1'b0;
        step(1);
        chk("midrst_an", {24'h0, an}, 32'hFF);
        chk("midrst_seg", {24'h0, seg}, 32'hFF);
        chk("midrst_sel", {27'h0, reg_sel}, 32'h0);
        rst = 1'b0;
        model_sel = 0;
        step(30);
        chk("midrst_nopress", {27'h0, reg_sel}, 32'h0);

        // Random data / hold against the frame model.
        for (int i = 0; i < 1500; i++) begin
            reg_data = $urandom;
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            step(1);
        end
        hold = 1'b0;

        // Random button pulse lengths.
        for (int i = 0; i < 16; i++) begin
            int nl, pl;
            nl = $urandom_range(0, 20);
            pl = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : 0;
            press_test(nl, pl, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule
